// File: rtl/sr_drive_pkg.sv
// sr_drive_gen shared types: FSM state encoding and counter sizing.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    S_PULSE = 2'd1,
    R_PULSE = 2'd2,
    GAP     = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_drive_gen_sync_debounce.sv
// Two-flop synchronizer plus debouncer for one raw button.
// ev_o pulses one cycle when the debounced level rises.
module sync_debounce
  import sr_drive_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic ev_o
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          lvl_d;
  logic          ev_q;
  logic          ev_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The flip happens on the mismatch that would take the count to DEB_CYCLES.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    ev_d  = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = s2_q;
        ev_d  = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      ev_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      ev_q  <= ev_d;
      cnt_q <= cnt_d;
    end
  end

  assign ev_o = ev_q;

endmodule

// File: rtl/sr_drive_gen.sv
// Clean, mutually exclusive active-low S/R pulse generator
// for an sr_latch, fed by two bouncing pushbuttons.
module sr_drive_gen
  import sr_drive_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic S,
  output logic R,
  output logic busy,
  output logic drop
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);

  logic          set_ev;
  logic          clr_ev;
  state_t        state_q;
  logic [PW-1:0] pcnt_q;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (set_req),
    .ev_o  (set_ev)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (clr_req),
    .ev_o  (clr_ev)
  );

  // Clear wins a tie; anything seen outside IDLE is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      S       <= 1'b1;
      R       <= 1'b1;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clr_ev) begin
            state_q <= R_PULSE;
            R       <= 1'b0;
            busy    <= 1'b1;
            pcnt_q  <= '0;
            drop    <= set_ev;
          end else if (set_ev) begin
            state_q <= S_PULSE;
            S       <= 1'b0;
            busy    <= 1'b1;
            pcnt_q  <= '0;
          end
        end
        S_PULSE, R_PULSE: begin
          drop <= set_ev | clr_ev;
          if (pcnt_q == PLAST) begin
            state_q <= GAP;
            S       <= 1'b1;
            R       <= 1'b1;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        GAP: begin
          drop    <= set_ev | clr_ev;
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_gen.sv
// Scoreboard bench for sr_drive_gen with a timeline reference model.
module tb_sr_drive_gen;

  localparam int DEB = 4;
  localparam int PUL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic S, R, busy, drop;
  logic lq = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  bit hs[$];
  bit hc[$];
  bit ls, lc, ps, pc;
  int free_at, b_lo, b_hi;
  int qs[$];
  int qr[$];
  int qd[$];

  sr_drive_gen #(.DEB_CYCLES(DEB), .PULSE_CYCLES(PUL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  always @(S or R) begin
    if (!S) lq = 1'b1;
    else if (!R) lq = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mreset();
    hs = {};
    hc = {};
    for (int i = 0; i < DEB + 2; i++) begin
      hs.push_back(1'b0);
      hc.push_back(1'b0);
    end
    ls = 0; lc = 0; ps = 0; pc = 0;
    free_at = 0; b_lo = 0; b_hi = -1;
    qs = {}; qr = {}; qd = {};
  endtask

  // Level flips when the DEB synchronized samples before this edge all differ.
  function automatic bit deb_flip(input bit h[$], input bit l);
    for (int i = 0; i < DEB; i++)
      if (h[h.size() - 2 - i] == l) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    bit ns, nc;
    int n;
    mreset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mreset();
      end else begin
        n = cyc;
        if (ps || pc) begin
          if (n >= free_at) begin
            if (pc) begin
              qr.push_back(n);
              if (ps) qd.push_back(n);
            end else begin
              qs.push_back(n);
            end
            free_at = n + PUL + 2;
            b_lo = n;
            b_hi = n + PUL;
          end else begin
            qd.push_back(n);
          end
        end
        ns = 0;
        nc = 0;
        if (deb_flip(hs, ls)) begin ls = !ls; ns = ls; end
        if (deb_flip(hc, lc)) begin lc = !lc; nc = lc; end
        hs.push_back(set_req); void'(hs.pop_front());
        hc.push_back(clr_req); void'(hc.pop_front());
        ps = ns;
        pc = nc;
      end
    end
  end

  initial begin
    bit pS = 1, pR = 1;
    int ss = 0, sr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_S", S, 1);
        chk("rst_R", R, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        pS = 1;
        pR = 1;
      end else begin
        chk("never_both_low", int'(!S && !R), 0);
        chk("busy", busy, int'(cyc >= b_lo && cyc <= b_hi));
        if (pS && !S) ss = cyc;
        if (!pS && S) begin
          if (qs.size() == 0) chk("S_pulse_unexpected", 1, 0);
          else begin
            chk("S_start", ss, qs.pop_front());
            chk("S_width", cyc - ss, PUL);
          end
        end
        if (pR && !R) sr = cyc;
        if (!pR && R) begin
          if (qr.size() == 0) chk("R_pulse_unexpected", 1, 0);
          else begin
            chk("R_start", sr, qr.pop_front());
            chk("R_width", cyc - sr, PUL);
          end
        end
        if (drop) begin
          if (qd.size() == 0) chk("drop_unexpected", 1, 0);
          else chk("drop_cycle", cyc, qd.pop_front());
        end
        pS = S;
        pR = R;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_s_low(output bit ok);
    int k = 0;
    while (S && k < 40) begin
      @(negedge clk);
      k++;
    end
    ok = !S;
  endtask

  initial begin
    int e0;
    bit ok;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(5);

    // clean set
    @(negedge clk);
    set_req = 1'b1;
    e0 = cyc + 1;
    wait_s_low(ok);
    if (!ok) chk("clean_S_timeout", 1, 0);
    else chk("clean_S_latency", cyc - e0, DEB + 2);
    idle(8);
    chk("clean_latch_Q", lq, 1);
    set_req = 1'b0;
    idle(12);

    // bounce
    for (int i = 0; i < 10; i++) begin
      set_req = ~set_req;
      idle(2);
    end
    set_req = 1'b0;
    idle(12);

    // simultaneous
    set_req = 1'b1;
    clr_req = 1'b1;
    idle(14);
    chk("simul_latch_Q", lq, 0);
    set_req = 1'b0;
    clr_req = 1'b0;
    idle(12);

    // clear while S pulse active
    set_req = 1'b1;
    idle(3);
    clr_req = 1'b1;
    idle(14);
    set_req = 1'b0;
    clr_req = 1'b0;
    idle(12);

    // reset mid-pulse
    set_req = 1'b1;
    wait_s_low(ok);
    if (!ok) chk("rst_mid_timeout", 1, 0);
    else begin
      @(posedge clk);
      #2 rst_n = 1'b0;
      set_req = 1'b0;
      #1 chk("rst_mid_S_async", S, 1);
      chk("rst_mid_busy_async", busy, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
    end
    idle(20);

    // button held through reset
    @(posedge clk);
    #2 rst_n = 1'b0;
    set_req = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(15);
    set_req = 1'b0;
    idle(12);

    // back-to-back
    set_req = 1'b1;
    idle(5);
    clr_req = 1'b1;
    idle(16);
    chk("b2b_latch_Q", lq, 0);
    set_req = 1'b0;
    clr_req = 1'b0;
    idle(12);

    // random
    for (int i = 0; i < 300; i++) begin
      set_req = 1'($urandom_range(0, 1));
      clr_req = 1'($urandom_range(0, 1));
      idle($urandom_range(1, 8));
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    idle(25);

    chk("qs_empty", qs.size(), 0);
    chk("qr_empty", qr.size(), 0);
    chk("qd_empty", qd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
